// File: rtl/clk_bringup_seq.sv
// Power-on clock bring-up sequencer: pulses the refclk generator reset, waits for the MMCM to lock,
// qualifies the lock as stable, then releases the PHY/MAC reset. Retries on lock timeout.
module clk_bringup_seq #(
    parameter int unsigned REFCLK_RST_CYCLES    = 1024,
    parameter int unsigned REFCLK_SETTLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES   = 256,
    parameter int unsigned MAX_RETRIES          = 3,
    parameter int unsigned CNT_W                = 17
) (
    input  logic       cfgmclk_int,
    input  logic       reset,
    input  logic       mmcm_locked,
    output logic       qsfp_refclk_reset,
    output logic       mmcm_rst,
    output logic       phy_sys_reset,
    output logic       bringup_done,
    output logic       bringup_fail,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_REFCLK_RST = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } state_e;

    // A phase ends on the edge where the counter shows its last value (N-1).
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(REFCLK_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(REFCLK_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       retry_inc;
    logic [1:0]       sync_q;
    logic             lock_s;

    assign lock_s    = sync_q[1];
    assign retry_inc = retry_q + 2'd1;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        unique case (state_q)
            ST_REFCLK_RST: if (cnt_q == RST_LAST) state_d = ST_SETTLE;
            ST_SETTLE:     if (cnt_q == SETTLE_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout edge wins over the retry.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_REFCLK_RST;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) state_d = ST_REFCLK_RST;
            end
            ST_FAIL: cnt_d = '0;
            default: begin
                state_d = ST_REFCLK_RST;
                retry_d = '0;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge cfgmclk_int) begin
        if (!reset) begin
            state_q           <= ST_REFCLK_RST;
            cnt_q             <= '0;
            retry_q           <= '0;
            sync_q            <= '0;
            qsfp_refclk_reset <= 1'b1;
            mmcm_rst          <= 1'b1;
            phy_sys_reset     <= 1'b1;
            bringup_done      <= 1'b0;
            bringup_fail      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            retry_q           <= retry_d;
            sync_q            <= {sync_q[0], mmcm_locked};
            qsfp_refclk_reset <= (state_d == ST_REFCLK_RST) || (state_d == ST_FAIL);
            mmcm_rst          <= (state_d == ST_REFCLK_RST) || (state_d == ST_SETTLE) ||
                                 (state_d == ST_FAIL);
            phy_sys_reset     <= (state_d != ST_RUN);
            bringup_done      <= (state_d == ST_RUN);
            bringup_fail      <= (state_d == ST_FAIL);
        end
    end

    assign retry_count = retry_q;
    assign state       = state_q;

endmodule
